// File: rtl/seq_det_sched.sv
// Purpose: runs one "010" detection session: clears the detector, shifts a frame into it LSB first, counts hits.
// Latency: start accepted at edge t -> res_valid first high in cycle t+2+len+DRAIN_CYC.
// Backpressure: the result is held in REPORT until res_ready; start is ignored while busy (not queued).
module seq_det_sched #(
  parameter int W         = 16,
  parameter int LW        = 5,
  parameter int CW        = 10,
  parameter int DRAIN_CYC = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [W-1:0]  i_frame_in,
  input  logic [LW-1:0] i_frame_len,
  output logic          o_busy,
  output logic          o_det_x,
  output logic          o_det_rst,
  input  logic          i_det_y,
  output logic          o_res_valid,
  input  logic          i_res_ready,
  output logic [CW-1:0] o_res_count,
  output logic          o_res_ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_REPORT
  } state_t;

  localparam logic [LW-1:0] LEN_MAX    = LW'(W);
  localparam logic [2:0]    DRAIN_LAST = 3'(DRAIN_CYC - 1);

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_frame;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_idx;
  logic [2:0]    r_dcnt;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic [LW-1:0] w_len_clamp;
  logic          w_last_bit;
  logic          w_last_drain;
  logic          w_count_en;

  // Over-long requests are clamped so the shifter never runs past the frame.
  assign w_len_clamp  = (i_frame_len > LEN_MAX) ? LEN_MAX : i_frame_len;
  assign w_last_bit   = (r_idx == (r_len - LW'(1)));
  assign w_last_drain = (r_dcnt == DRAIN_LAST);
  // Detector hits only count while bits are in flight or draining.
  assign w_count_en   = ((r_state == S_SHIFT) || (r_state == S_DRAIN)) && i_det_y;

  assign o_res_count  = r_count;
  assign o_res_ovf    = r_ovf;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and outputs; the idle line level 1 can never complete "010".
  always_comb begin
    w_next      = r_state;
    o_busy      = 1'b1;
    o_det_x     = 1'b1;
    o_det_rst   = i_rst;
    o_res_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        o_det_rst = 1'b1;
        if (r_len != '0)        w_next = S_SHIFT;
        else if (DRAIN_CYC > 0) w_next = S_DRAIN;
        else                    w_next = S_REPORT;
      end
      S_SHIFT: begin
        o_det_x = r_frame[0];
        if (w_last_bit) w_next = (DRAIN_CYC > 0) ? S_DRAIN : S_REPORT;
      end
      S_DRAIN: begin
        if (w_last_drain) w_next = S_REPORT;
      end
      S_REPORT: begin
        o_res_valid = 1'b1;
        if (i_res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Frame capture/shift, bit and drain counters, saturating hit counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_dcnt  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_idx  <= (r_state == S_SHIFT) ? r_idx + LW'(1) : '0;
      r_dcnt <= (r_state == S_DRAIN) ? r_dcnt + 3'd1 : '0;
      if (r_state == S_SHIFT) r_frame <= r_frame >> 1;
      if ((r_state == S_IDLE) && i_start) begin
        r_frame <= i_frame_in;
        r_len   <= w_len_clamp;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_count_en) begin
        if (&r_count) r_ovf   <= 1'b1;
        else          r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: doc/seq_det_sched.md
Name: seq_det_sched

Overview:
Controller that runs one detection session on the serial "010" sequence-detector datapath. It accepts a parallel frame on a start pulse and resets the detector. It then serializes the frame into the detector's x input one bit per clock and counts the detector's y pulses. The result is returned on a valid/ready handshake. It sits between a host/register block and one detector instance, and is the only driver of that detector's x and reset.

Parameters:
W, 16, frame width in bits
LW, 5, width of frame_len; must hold values 0..W
CW, 10, hit-counter width
DRAIN_CYC, 1, cycles y is still sampled after the last bit (covers registered detector variants); range 0..7

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  request a session; accepted only in IDLE
frame_in  in  W  bits to send, LSB first; sampled on accepted start
frame_len  in  LW  number of bits to send; sampled on accepted start
busy  out  1  high in every state except IDLE
det_x  out  1  serial bit to detector x
det_rst  out  1  detector reset, active-high
det_y  in  1  detector hit pulse, sampled every cycle in SHIFT and DRAIN
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_count  out  CW  hits counted in the session
res_ovf  out  1  hit count saturated

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, det_x=1, res_valid=0, res_count=0, res_ovf=0, internal bit index=0.
- det_rst = rst OR (state==CLEAR). It is asserted combinationally during controller reset, including reset mid-session.
- det_x = 1 in every state except SHIFT. The idle level 1 cannot complete a "010" pattern.
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, REPORT.
- IDLE:
  - start=1 latches frame_in, and latches len = min(frame_len, W).
  - Clears the hit counter and res_ovf, then goes to CLEAR.
- CLEAR: exactly 1 cycle with det_rst=1.
  - Next state is SHIFT if len>0.
  - Next state is DRAIN if len==0 and DRAIN_CYC>0, otherwise REPORT.
- SHIFT:
  - Cycle i (i=0..len-1) drives det_x = frame[i].
  - After cycle len-1, go to DRAIN (or REPORT if DRAIN_CYC==0).
- DRAIN: DRAIN_CYC cycles with det_x=1, then REPORT.
- Hit counting:
  - In SHIFT and DRAIN, each cycle with det_y=1 increments the counter by 1.
  - The counter saturates at 2^CW-1; an increment attempted at saturation sets res_ovf=1 (sticky for the session).
  - det_y is ignored in IDLE, CLEAR and REPORT.
- REPORT:
  - res_valid=1; res_count and res_ovf are stable while res_valid=1.
  - On res_valid & res_ready, go to IDLE and drop res_valid the next cycle.
  - res_count and res_ovf keep their values in IDLE until the next accepted start.
- Latency: start accepted at edge t gives CLEAR in cycle t+1, SHIFT in cycles t+2..t+1+len, and res_valid first high in cycle t+2+len+DRAIN_CYC.
- start while busy=1 (including REPORT) is ignored, not queued. A start in the same cycle as the REPORT handshake is ignored; the next start is accepted from IDLE.
- frame_in and frame_len changing after acceptance have no effect on the session.
- rst mid-session aborts immediately to the reset values. No result is produced.

Test Plan:
- Single hit: frame_in=0x0002, frame_len=3, DRAIN_CYC=1 (sends 0,1,0). Required: det_x pattern 0,1,0; res_count=1, res_ovf=0; res_valid first high 6 cycles after the start edge.
- Overlap not counted: frame_in=0x000A, frame_len=5 (sends 0,1,0,1,0). Required: res_count=1, because the detector does not report the overlapping second pattern.
- Two hits: frame_in=0x0012, frame_len=6 (sends 0,1,0,0,1,0). Required: res_count=2. A second start asserted during SHIFT is ignored and busy stays 1.
- Boundaries:
  - frame_len=0 gives res_count=0, with det_rst pulsed once and no SHIFT cycles.
  - frame_len=20 with W=16 clamps to 16 bits sent.
- Backpressure and overflow:
  - Hold res_ready=0 for 10 cycles: res_valid stays 1 and res_count stays stable; the handshake then returns to IDLE.
  - With CW=1, a frame containing 2 hits gives res_count=1 and res_ovf=1.
- Reset mid-session: assert rst during SHIFT bit 3. Required: det_rst=1 that cycle; next cycle IDLE with busy=0, res_valid=0, det_x=1. A new session afterwards produces the correct count.
